squash_unit_tree: RTL
=====================

Name: squash_unit_tree

Overview:
Parametrised successor to the L1 chain squash unit. It arbitrates up to p_num_arb squash notifications per cycle and selects the oldest by sequence-number age. Age is measured relative to an internally tracked commit base. Selection uses a radix-p_radix comparator tree, the grant is registered, and an optional suppression window drops squashes younger than an already-granted, not-yet-committed squash. It sits between the execute/branch units (squash sources) and fetch/ROB (squash consumers).

Parameters:
p_num_arb, 2, number of squash sources (>=1)
p_seq_num_bits, 5, sequence number width (>=2)
p_radix, 4, fan-in per comparator tree node (>=2)
p_suppress, 1, 1 = enable younger-squash suppression window; 0 = pure oldest-wins arbiter

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
arb_val  in  p_num_arb  per-source squash valid (SquashNotif arb[i].val)
arb_seq_num  in  p_num_arb x p_seq_num_bits  per-source squashing seq num
arb_target  in  p_num_arb x 32  per-source redirect target
commit_val  in  1  commit notification valid (CommitNotif.val)
commit_seq_num  in  p_seq_num_bits  committed seq num; other CommitNotif fields unused
gnt_val  out  1  granted squash valid (SquashNotif gnt.val)
gnt_seq_num  out  p_seq_num_bits  granted seq num
gnt_target  out  32  granted target

Behaviour:
- One clock; reset is asynchronous and active-low. Assertion clears immediately: gnt_val=0, gnt_seq_num=0, gnt_target=0, base_q=0, act_val_q=0, act_seq_q=0. Mid-operation reset discards any in-flight grant.
- Valid-only interfaces, no backpressure. A squash presented for one cycle is either granted or dropped; never queued.
- Age: age(x) = (x - base_q) mod 2^p_seq_num_bits, unsigned. Smaller age = older. Wrap-around is implicit in the modular subtract.
- Commit base: on commit_val, base_q <= commit_seq_num + 1 (mod 2^bits). Arbitration in the same cycle uses the old base_q.
- Candidate i: arb_val[i] && !supp[i].
  - supp[i] = p_suppress && act_val_q && age(arb_seq_num[i]) >= age(act_seq_q).
  - Equal seq to the active squash counts as a duplicate and is dropped.
- Tree selection is combinational, ceil(log_p_radix(p_num_arb)) levels.
  - Each node picks the smallest-age valid input.
  - Ties are broken by the lowest source index, at every level, so the lowest global index wins.
- Output register, latency exactly 1 cycle:
  - Any candidate: gnt_val<=1, gnt_seq_num/gnt_target <= winner fields.
  - No candidate: gnt_val<=0, gnt_seq_num/gnt_target hold their previous values.
- Suppression window (p_suppress=1 only):
  - On a grant: act_val_q<=1, act_seq_q<=winner seq. A winner is always older than the active squash, so it replaces it.
  - Clear: commit_val && age(commit_seq_num) >= age(act_seq_q), evaluated with the old base → act_val_q<=0.
  - Grant and clear in the same cycle: the grant wins; act is set to the new seq.
- p_suppress=0: act registers tie to 0 and every valid input is a candidate.
- p_num_arb=1: the tree degenerates to a wire, and suppression still applies.

Decomposition:
- Package squash_pkg:
  - parametrised struct t_squash_msg {seq_num, target}
  - function seq_age(seq, base, bits)
- Sub-module squash_tree_node: p_radix-input oldest-select with valid and index tie-break. It is instantiated recursively/generated per level in squash_unit_tree.
- Base and act registers plus the output register live in the top module.

Test Plan:
(bits=5, p_num_arb=4, p_radix=2 unless noted)
1. Reset: hold rst=0 with arb_val=4'b1111 → gnt_val=0 throughout; after release with no inputs, gnt_val stays 0; assert rst mid-grant → gnt_val drops without waiting for a clock edge.
2. Single source: base 0, arb2 seq 7 target 0x100 → next cycle gnt_val=1, seq 7, target 0x100; following cycle gnt_val=0.
3. Age vs base: commit 3 (base=4); then arb0 seq 2 (age 30), arb1 seq 9 (age 5), arb3 seq 5 (age 1) → gnt seq 5, arb3's target.
4. Wrap: commit 29 (base=30); arb0 seq 1 (age 3), arb1 seq 31 (age 1) → gnt seq 31.
5. Suppression: grant seq 10; next cycle arb2 seq 12 → gnt_val=0; arb1 seq 8 → gnt seq 8; commit 8 → window clears; arb2 seq 12 → gnt seq 12. Rerun with p_suppress=0 → seq 12 granted immediately.
6. Tie and sweep: arb1 and arb3 both seq 6, targets 0xA/0xB → gnt target 0xA; repeat the oldest-select randomly for p_num_arb ∈ {1,5,20}, p_radix ∈ {2,3,4} against a reference age model.

Source files
------------

// File: rtl/squash_pkg.sv
// Shared helpers for the squash arbiter: modular sequence age and
// elaboration-time sizing of the radix comparator tree.
package squash_pkg;

  localparam int unsigned c_target_bits = 32;

  // Distance of seq ahead of base, modulo 2^bits; smaller means older.
  function automatic logic [31:0] seq_age(input logic [31:0] seq,
                                          input logic [31:0] base,
                                          input int unsigned bits);
    logic [31:0] mask;
    mask = (bits >= 32) ? '1 : ((32'd1 << bits) - 32'd1);
    return (seq - base) & mask;
  endfunction

  function automatic int unsigned pow_int(input int unsigned b, input int unsigned e);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  function automatic int unsigned tree_levels(input int unsigned n, input int unsigned radix);
    int unsigned l;
    int unsigned cap;
    l   = 0;
    cap = 1;
    while (cap < n) begin
      cap = cap * radix;
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/squash_tree_node.sv
// One comparator-tree node: selects the oldest valid input relative to i_base,
// lowest input position winning ties. Payload carries seq_num in its top bits.
module squash_tree_node
  import squash_pkg::*;
#(
  parameter int unsigned p_radix     = 2,
  parameter int unsigned p_seq_bits  = 5,
  parameter int unsigned p_data_bits = 37
) (
  input  logic [p_seq_bits-1:0]                 i_base,
  input  logic [p_radix-1:0]                    i_val,
  input  logic [p_radix-1:0][p_data_bits-1:0]   i_data,
  output logic                                  o_val,
  output logic [p_data_bits-1:0]                o_data
);

  logic [p_seq_bits-1:0] w_age;
  logic [p_seq_bits-1:0] w_best_age;

  always_comb begin
    o_val      = 1'b0;
    o_data     = '0;
    w_age      = '0;
    w_best_age = '0;
    for (int unsigned j = 0; j < p_radix; j++) begin
      w_age = p_seq_bits'(seq_age(32'(i_data[j][p_data_bits-1 -: p_seq_bits]),
                                  32'(i_base), p_seq_bits));
      // Strict less-than keeps the earlier position on equal age.
      if (i_val[j] && (!o_val || (w_age < w_best_age))) begin
        o_val      = 1'b1;
        o_data     = i_data[j];
        w_best_age = w_age;
      end
    end
  end

endmodule

// File: rtl/squash_unit_tree.sv
// Oldest-first squash arbiter: radix comparator tree over per-source squashes,
// registered grant, commit-tracked age base and optional younger-squash window.
module squash_unit_tree
  import squash_pkg::*;
#(
  parameter int unsigned p_num_arb      = 2,
  parameter int unsigned p_seq_num_bits = 5,
  parameter int unsigned p_radix        = 4,
  parameter int unsigned p_suppress     = 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [p_num_arb-1:0]                          arb_val,
  input  logic [p_num_arb-1:0][p_seq_num_bits-1:0]      arb_seq_num,
  input  logic [p_num_arb-1:0][c_target_bits-1:0]       arb_target,
  input  logic                                          commit_val,
  input  logic [p_seq_num_bits-1:0]                     commit_seq_num,
  output logic                                          gnt_val,
  output logic [p_seq_num_bits-1:0]                     gnt_seq_num,
  output logic [c_target_bits-1:0]                      gnt_target
);

  typedef struct packed {
    logic [p_seq_num_bits-1:0] seq_num;
    logic [c_target_bits-1:0]  target;
  } t_squash_msg;

  localparam int unsigned c_levels   = tree_levels(p_num_arb, p_radix);
  localparam int unsigned c_msg_bits = $bits(t_squash_msg);

  function automatic logic [p_seq_num_bits-1:0] age_of(input logic [p_seq_num_bits-1:0] s,
                                                       input logic [p_seq_num_bits-1:0] b);
    return p_seq_num_bits'(seq_age(32'(s), 32'(b), p_seq_num_bits));
  endfunction

  logic                       r_gnt_val;
  t_squash_msg                r_gnt;
  logic [p_seq_num_bits-1:0]  r_base;

  logic                       w_act_val;
  logic [p_seq_num_bits-1:0]  w_act_seq;
  logic [p_seq_num_bits-1:0]  w_act_age;
  logic [p_num_arb-1:0]       w_cand;
  logic                       w_win_val;
  t_squash_msg                w_win;

  // Anything not strictly older than the live squash is already covered by it.
  always_comb begin
    w_cand    = '0;
    w_act_age = age_of(w_act_seq, r_base);
    for (int unsigned i = 0; i < p_num_arb; i++) begin
      w_cand[i] = arb_val[i] &&
                  !(w_act_val && (age_of(arb_seq_num[i], r_base) >= w_act_age));
    end
  end

  for (genvar l = 0; l <= c_levels; l++) begin : g_lvl
    localparam int unsigned c_n = pow_int(p_radix, c_levels - l);
    logic [c_n-1:0]                  w_val;
    logic [c_n-1:0][c_msg_bits-1:0]  w_data;

    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < c_n; i++) begin : g_in
        if (i < p_num_arb) begin : g_src
          assign w_val[i]  = w_cand[i];
          assign w_data[i] = t_squash_msg'{seq_num: arb_seq_num[i], target: arb_target[i]};
        end else begin : g_pad
          assign w_val[i]  = 1'b0;
          assign w_data[i] = '0;
        end
      end
    end else begin : g_node
      for (genvar n = 0; n < c_n; n++) begin : g_n
        squash_tree_node #(
          .p_radix     (p_radix),
          .p_seq_bits  (p_seq_num_bits),
          .p_data_bits (c_msg_bits)
        ) u_node (
          .i_base (r_base),
          .i_val  (g_lvl[l-1].w_val[n*p_radix +: p_radix]),
          .i_data (g_lvl[l-1].w_data[n*p_radix +: p_radix]),
          .o_val  (w_val[n]),
          .o_data (w_data[n])
        );
      end
    end
  end

  assign w_win_val = g_lvl[c_levels].w_val[0];
  assign w_win     = t_squash_msg'(g_lvl[c_levels].w_data[0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt_val <= 1'b0;
      r_gnt     <= '0;
      r_base    <= '0;
    end else begin
      r_gnt_val <= w_win_val;
      if (w_win_val) r_gnt <= w_win;
      if (commit_val) r_base <= commit_seq_num + p_seq_num_bits'(1);
    end
  end

  if (p_suppress != 0) begin : g_supp
    logic                       r_act_val;
    logic [p_seq_num_bits-1:0]  r_act_seq;
    logic                       w_clear;

    assign w_clear = commit_val && (age_of(commit_seq_num, r_base) >= w_act_age);

    // A new grant is always older than the live one, so it simply replaces it.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_act_val <= 1'b0;
        r_act_seq <= '0;
      end else if (w_win_val) begin
        r_act_val <= 1'b1;
        r_act_seq <= w_win.seq_num;
      end else if (w_clear) begin
        r_act_val <= 1'b0;
      end
    end

    assign w_act_val = r_act_val;
    assign w_act_seq = r_act_seq;
  end else begin : g_nosupp
    assign w_act_val = 1'b0;
    assign w_act_seq = '0;
  end

  assign gnt_val     = r_gnt_val;
  assign gnt_seq_num = r_gnt.seq_num;
  assign gnt_target  = r_gnt.target;

endmodule
